fixed_encoder: RTL and testbench

- FLAC fixed-predictor encoder: turns a 16-bit PCM sample stream into fixed-predictor residuals of a selectable order (0..4).
- In parallel, accumulates |residual| for all five orders over each block and reports the cheapest order at block end.
- Sits upstream of the Rice coder; it is the inverse of the fixed-order decoders in the decode path.

---
 rtl/fixed_enc_pkg.sv | 21 ++
 rtl/fixed_abs_accumulator.sv | 45 ++++
 rtl/fixed_encoder.sv | 188 ++++++++++++++++++
 tb/tb_fixed_encoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_enc_pkg.sv
// Shared widths, order limits and helpers for the FLAC fixed-predictor encoder.
package fixed_enc_pkg;

    localparam int unsigned DefaultDataWidth = 16;
    localparam int unsigned DefaultResWidth  = 21;
    localparam int unsigned DefaultSumWidth  = 32;
    localparam int unsigned MaxOrder         = 4;
    localparam int unsigned NumOrders        = MaxOrder + 1;
    localparam int unsigned WarmupStatsStart = 4;
    localparam int unsigned IdxSat           = 5;

    typedef logic signed [DefaultResWidth-1:0] res_t;
    typedef logic [DefaultSumWidth-1:0]        sum_t;
    typedef logic [2:0]                        order_t;

    // Orders 5..7 behave as order 4.
    function automatic order_t clamp_order(input order_t order);
        return (order > order_t'(MaxOrder)) ? order_t'(MaxOrder) : order;
    endfunction

endpackage

// File: rtl/fixed_abs_accumulator.sv
// Per-order |residual| accumulator: saturating add, clear on block start,
// snapshot of the final sum on block end.
module fixed_abs_accumulator
    import fixed_enc_pkg::*;
#(
    parameter int unsigned RES_WIDTH = DefaultResWidth,
    parameter int unsigned SUM_WIDTH = DefaultSumWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    input  logic                        start_i,
    input  logic                        stats_i,
    input  logic                        end_i,
    input  logic signed [RES_WIDTH-1:0] value_i,
    output logic [SUM_WIDTH-1:0]        sum_o
);

    logic [RES_WIDTH-1:0] mag;
    logic [SUM_WIDTH-1:0] base, addend, acc_d, acc_q, snap_q;
    logic [SUM_WIDTH:0]   total;

    always_comb begin
        mag    = value_i[RES_WIDTH-1] ? RES_WIDTH'(-value_i) : RES_WIDTH'(value_i);
        base   = start_i ? '0 : acc_q;
        addend = stats_i ? {{(SUM_WIDTH-RES_WIDTH){1'b0}}, mag} : '0;
        total  = {1'b0, base} + {1'b0, addend};
        acc_d  = total[SUM_WIDTH] ? '1 : total[SUM_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else if (valid_i) begin
            acc_q <= acc_d;
            if (end_i) begin
                snap_q <= acc_d;
            end
        end
    end

    assign sum_o = snap_q;

endmodule

// File: rtl/fixed_encoder.sv
// FLAC fixed-predictor encoder: 2-stage residual pipeline for the selected
// order plus per-block abs-sum statistics for all five orders.
module fixed_encoder
    import fixed_enc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned RES_WIDTH  = DefaultResWidth,
    parameter int unsigned SUM_WIDTH  = DefaultSumWidth
) (
    input  logic                         iClock,
    input  logic                         iReset,
    input  logic                         iEnable,
    input  logic                         iBlockStart,
    input  logic                         iBlockEnd,
    input  logic [2:0]                   iOrder,
    input  logic signed [DATA_WIDTH-1:0] iSample,
    output logic                         oValid,
    output logic                         oWarmup,
    output logic signed [RES_WIDTH-1:0]  oResidual,
    output logic                         oDone,
    output logic [2:0]                   oBestOrder,
    output logic [SUM_WIDTH-1:0]         oSum0,
    output logic [SUM_WIDTH-1:0]         oSum1,
    output logic [SUM_WIDTH-1:0]         oSum2,
    output logic [SUM_WIDTH-1:0]         oSum3,
    output logic [SUM_WIDTH-1:0]         oSum4
);

    typedef logic signed [RES_WIDTH-1:0] wide_t;

    wide_t      x_ext;
    wide_t      h      [1:4];
    wide_t      hist_q [1:4];
    logic [2:0] idx_q, idx_eff, k_q, k_eff;
    logic       in_block_q;

    wide_t      pos_d [NumOrders];
    wide_t      neg_d [NumOrders];
    wide_t      s1_pos_q [NumOrders];
    wide_t      s1_neg_q [NumOrders];
    logic       s1_valid_q, s1_warm_q, s1_stats_q, s1_start_q, s1_end_q;
    logic [2:0] s1_k_q;

    wide_t      e_d  [NumOrders];
    wide_t      s2_e_q [NumOrders];
    wide_t      res_d, s2_res_q;
    logic       s2_valid_q, s2_warm_q, s2_stats_q, s2_start_q, s2_end_q;
    logic       done_q;

    logic [SUM_WIDTH-1:0] sums [NumOrders];
    logic [SUM_WIDTH-1:0] min_sum;
    logic [2:0]           best;

    // Stage 1: positive and negative binomial terms, shift/add only.
    always_comb begin
        x_ext = {{(RES_WIDTH-DATA_WIDTH){iSample[DATA_WIDTH-1]}}, iSample};
        for (int n = 1; n <= 4; n++) begin
            h[n] = iBlockStart ? '0 : hist_q[n];
        end
        idx_eff  = iBlockStart ? '0 : idx_q;
        k_eff    = iBlockStart ? clamp_order(iOrder) : k_q;
        pos_d[0] = x_ext;
        neg_d[0] = '0;
        pos_d[1] = x_ext;
        neg_d[1] = h[1];
        pos_d[2] = x_ext + h[2];
        neg_d[2] = h[1] <<< 1;
        pos_d[3] = x_ext + (h[2] <<< 1) + h[2];
        neg_d[3] = (h[1] <<< 1) + h[1] + h[3];
        pos_d[4] = x_ext + (h[2] <<< 2) + (h[2] <<< 1) + h[4];
        neg_d[4] = (h[1] <<< 2) + (h[3] <<< 2);
    end

    // Stage 2: final subtraction and order mux.
    always_comb begin
        for (int n = 0; n < int'(NumOrders); n++) begin
            e_d[n] = s1_pos_q[n] - s1_neg_q[n];
        end
        case (s1_k_q)
            3'd0:    res_d = e_d[0];
            3'd1:    res_d = e_d[1];
            3'd2:    res_d = e_d[2];
            3'd3:    res_d = e_d[3];
            default: res_d = e_d[4];
        endcase
        if (s1_warm_q) begin
            res_d = s1_pos_q[0];
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            for (int n = 1; n <= 4; n++) begin
                hist_q[n] <= '0;
            end
            for (int n = 0; n < int'(NumOrders); n++) begin
                s1_pos_q[n] <= '0;
                s1_neg_q[n] <= '0;
                s2_e_q[n]   <= '0;
            end
            idx_q      <= '0;
            k_q        <= '0;
            in_block_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_warm_q  <= 1'b0;
            s1_stats_q <= 1'b0;
            s1_start_q <= 1'b0;
            s1_end_q   <= 1'b0;
            s1_k_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_warm_q  <= 1'b0;
            s2_stats_q <= 1'b0;
            s2_start_q <= 1'b0;
            s2_end_q   <= 1'b0;
            s2_res_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            s1_valid_q <= iEnable;
            if (iEnable) begin
                hist_q[1]  <= x_ext;
                hist_q[2]  <= h[1];
                hist_q[3]  <= h[2];
                hist_q[4]  <= h[3];
                idx_q      <= (idx_eff >= 3'(IdxSat)) ? 3'(IdxSat) : idx_eff + 3'd1;
                k_q        <= k_eff;
                in_block_q <= iBlockEnd ? 1'b0 : (iBlockStart | in_block_q);
                s1_pos_q   <= pos_d;
                s1_neg_q   <= neg_d;
                s1_warm_q  <= idx_eff < k_eff;
                s1_stats_q <= idx_eff >= 3'(WarmupStatsStart);
                s1_start_q <= iBlockStart;
                // Ends are reported only for blocks that actually started.
                s1_end_q   <= iBlockEnd & (iBlockStart | in_block_q);
                s1_k_q     <= k_eff;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_e_q     <= e_d;
                s2_res_q   <= res_d;
                s2_warm_q  <= s1_warm_q;
                s2_stats_q <= s1_stats_q;
                s2_start_q <= s1_start_q;
                s2_end_q   <= s1_end_q;
            end
            done_q <= s2_valid_q & s2_end_q;
        end
    end

    for (genvar g = 0; g < int'(NumOrders); g++) begin : g_acc
        fixed_abs_accumulator #(
            .RES_WIDTH (RES_WIDTH),
            .SUM_WIDTH (SUM_WIDTH)
        ) u_acc (
            .clk_i   (iClock),
            .rst_ni  (iReset),
            .valid_i (s2_valid_q),
            .start_i (s2_start_q),
            .stats_i (s2_stats_q),
            .end_i   (s2_end_q),
            .value_i (s2_e_q[g]),
            .sum_o   (sums[g])
        );
    end

    // Argmin over the held snapshots; strict compare keeps ties on the lower order.
    always_comb begin
        best    = '0;
        min_sum = sums[0];
        for (int n = 1; n < int'(NumOrders); n++) begin
            if (sums[n] < min_sum) begin
                min_sum = sums[n];
                best    = 3'(n);
            end
        end
    end

    assign oValid     = s2_valid_q;
    assign oWarmup    = s2_warm_q;
    assign oResidual  = s2_res_q;
    assign oDone      = done_q;
    assign oBestOrder = best;
    assign oSum0      = sums[0];
    assign oSum1      = sums[1];
    assign oSum2      = sums[2];
    assign oSum3      = sums[3];
    assign oSum4      = sums[4];

endmodule

// File: tb/tb_fixed_encoder.sv
// Randomized scoreboard bench for fixed_encoder with a binomial-difference
// reference model and an order-3 round-trip decoder in the monitor.
module tb_fixed_encoder;

    localparam int DW = 16;
    localparam int RW = 21;
    localparam int SW = 32;
    localparam longint SumMax = 64'hFFFF_FFFF;

    logic                 iClock = 1'b0;
    logic                 iReset = 1'b0;
    logic                 iEnable = 1'b0;
    logic                 iBlockStart = 1'b0;
    logic                 iBlockEnd = 1'b0;
    logic [2:0]           iOrder = '0;
    logic signed [DW-1:0] iSample = '0;
    logic                 oValid, oWarmup, oDone;
    logic signed [RW-1:0] oResidual;
    logic [2:0]           oBestOrder;
    logic [SW-1:0]        oSum0, oSum1, oSum2, oSum3, oSum4;

    fixed_encoder u_dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iEnable     (iEnable),
        .iBlockStart (iBlockStart),
        .iBlockEnd   (iBlockEnd),
        .iOrder      (iOrder),
        .iSample     (iSample),
        .oValid      (oValid),
        .oWarmup     (oWarmup),
        .oResidual   (oResidual),
        .oDone       (oDone),
        .oBestOrder  (oBestOrder),
        .oSum0       (oSum0),
        .oSum1       (oSum1),
        .oSum2       (oSum2),
        .oSum3       (oSum3),
        .oSum4       (oSum4)
    );

    always #5 iClock = ~iClock;

    int cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    typedef struct {
        int     cyc;
        bit     warm;
        longint res;
        bit     rt;
        bit     rt_start;
        longint sample;
    } res_exp_t;

    typedef struct {
        int              cyc;
        logic [4:0][31:0] sums;
        int              best;
    } done_exp_t;

    res_exp_t  rq[$];
    done_exp_t dq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model state: the samples of the current block, its order and sums.
    longint blk[$];
    int     mk = 0;
    bit     m_in = 0;
    longint msum[5];

    function automatic longint choose(input int n, input int j);
        longint r = 1;
        for (int t = 0; t < j; t++) r = r * (n - t) / (t + 1);
        return r;
    endfunction

    task automatic model_reset();
        blk.delete();
        mk   = 0;
        m_in = 0;
        for (int n = 0; n < 5; n++) msum[n] = 0;
    endtask

    task automatic send(input longint x, input bit st, input bit en, input int ord, input bit rt);
        longint   e[5];
        int       i;
        res_exp_t r;
        done_exp_t d;
        if (st) begin
            blk.delete();
            mk   = (ord > 4) ? 4 : ord;
            m_in = 1;
            for (int n = 0; n < 5; n++) msum[n] = 0;
        end
        blk.push_back(x);
        i = blk.size() - 1;
        for (int n = 0; n < 5; n++) begin
            e[n] = 0;
            for (int j = 0; j <= n; j++) begin
                if (i - j >= 0)
                    e[n] += ((j % 2) ? -1 : 1) * choose(n, j) * blk[i - j];
            end
        end
        r.cyc      = cyc + 2;
        r.warm     = (i < mk);
        r.res      = r.warm ? x : e[mk];
        r.rt       = rt;
        r.rt_start = st;
        r.sample   = x;
        rq.push_back(r);
        if (i >= 4) begin
            for (int n = 0; n < 5; n++) begin
                msum[n] += (e[n] < 0) ? -e[n] : e[n];
                if (msum[n] > SumMax) msum[n] = SumMax;
            end
        end
        if (en && m_in) begin
            d.cyc  = cyc + 3;
            d.best = 0;
            for (int n = 0; n < 5; n++) d.sums[n] = 32'(msum[n]);
            for (int n = 1; n < 5; n++) if (msum[n] < msum[d.best]) d.best = n;
            dq.push_back(d);
            m_in = 0;
        end
        iEnable     = 1'b1;
        iBlockStart = st;
        iBlockEnd   = en;
        iOrder      = 3'(ord);
        iSample     = DW'(x);
        @(posedge iClock);
        #1;
        iEnable     = 1'b0;
        iBlockStart = 1'b0;
        iBlockEnd   = 1'b0;
    endtask

    // Idle cycles carry junk on the qualified inputs, which must be ignored.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            iEnable     = 1'b0;
            iBlockStart = 1'($urandom);
            iBlockEnd   = 1'($urandom);
            iOrder      = 3'($urandom);
            iSample     = DW'($urandom);
            @(posedge iClock);
            #1;
        end
        iBlockStart = 1'b0;
        iBlockEnd   = 1'b0;
    endtask

    function automatic longint rnd_sample();
        logic signed [DW-1:0] t;
        case ($urandom_range(0, 5))
            0:       return 32767;
            1:       return -32768;
            default: begin
                t = DW'($urandom);
                return longint'(t);
            end
        endcase
    endfunction

    task automatic random_block(input int len, input int ord, input bit gaps, input bit rt);
        for (int i = 0; i < len; i++) begin
            send(rnd_sample(), i == 0, i == len - 1, ord, rt);
            if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, longint'(oValid), 0);
        chk({tag, "_warmup"}, longint'(oWarmup), 0);
        chk({tag, "_residual"}, longint'(oResidual), 0);
        chk({tag, "_done"}, longint'(oDone), 0);
        chk({tag, "_best"}, longint'(oBestOrder), 0);
        chk({tag, "_sums"}, longint'(oSum0 | oSum1 | oSum2 | oSum3 | oSum4), 0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a residual or a done pulse.
    longint d1 = 0, d2 = 0, d3 = 0;
    always @(negedge iClock) begin
        if (iReset) begin
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("residual_missing", 0, 1);
                void'(rq.pop_front());
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                chk("done_missing", 0, 1);
                void'(dq.pop_front());
            end
            if (oValid) begin
                if (rq.size() == 0 || rq[0].cyc != cyc) begin
                    chk("residual_unexpected", 1, 0);
                end else begin
                    res_exp_t r;
                    longint   dec;
                    r = rq.pop_front();
                    chk("warmup", longint'(oWarmup), longint'(r.warm));
                    chk("residual", longint'(oResidual), r.res);
                    if (r.rt) begin
                        if (r.rt_start) begin
                            d1 = 0;
                            d2 = 0;
                            d3 = 0;
                        end
                        dec = oWarmup ? longint'(oResidual)
                                      : longint'(oResidual) + 3 * d1 - 3 * d2 + d3;
                        chk("roundtrip_o3", dec, r.sample);
                        d3 = d2;
                        d2 = d1;
                        d1 = dec;
                    end
                end
            end
            if (oDone) begin
                if (dq.size() == 0 || dq[0].cyc != cyc) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    done_exp_t d;
                    d = dq.pop_front();
                    chk("sum0", longint'(oSum0), longint'(d.sums[0]));
                    chk("sum1", longint'(oSum1), longint'(d.sums[1]));
                    chk("sum2", longint'(oSum2), longint'(d.sums[2]));
                    chk("sum3", longint'(oSum3), longint'(d.sums[3]));
                    chk("sum4", longint'(oSum4), longint'(d.sums[4]));
                    chk("best_order", longint'(oBestOrder), longint'(d.best));
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge iClock);
        #1;
        check_all_zero("reset");
        iReset = 1'b1;
        @(posedge iClock);
        #1;

        for (int i = 0; i < 10; i++) send(i, i == 0, i == 9, 2, 0);
        idle(2);
        for (int i = 0; i < 8; i++) send(100, i == 0, i == 7, 1, 0);
        idle(1);
        for (int i = 0; i < 5; i++) send((i % 2) ? -32768 : 32767, i == 0, i == 4, 4, 0);

        // 1-sample block, then a block starting in the very next cycle, with gaps.
        send(rnd_sample(), 1, 1, $urandom_range(0, 7), 0);
        random_block(12, $urandom_range(0, 7), 1, 0);

        for (int b = 0; b < 6; b++) random_block($urandom_range(1, 20), $urandom_range(0, 7), 1, 0);

        // Restart mid-block: the first block is abandoned.
        for (int i = 0; i < 7; i++) send(rnd_sample(), i == 0, 0, 3, 0);
        random_block(9, 2, 0, 0);
        idle(2);

        random_block(1000, 3, 1, 1);
        idle(3);

        // Reset after 6 samples of a block.
        for (int i = 0; i < 6; i++) send(rnd_sample(), i == 0, 0, 4, 0);
        iReset = 1'b0;
        rq.delete();
        dq.delete();
        model_reset();
        @(negedge iClock);
        check_all_zero("midreset");
        @(posedge iClock);
        #1;
        iReset = 1'b1;
        @(posedge iClock);
        #1;

        // Samples before any block start are processed but never reported.
        for (int i = 0; i < 3; i++) send(rnd_sample(), 0, i == 2, 0, 0);
        random_block(8, 4, 1, 0);
        random_block(10, 1, 0, 0);

        idle(8);
        chk("residual_queue_drained", rq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
